framebuffer_arbiter: RTL and testbench
======================================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 SHALL have parameter COLOR_W, default 30, meaning pixel width (10b R, 10b G, 10b B).
REQ-002 SHALL have parameter H_PIX, default 320, meaning framebuffer width in pixels.
REQ-003 SHALL have parameter V_PIX, default 240, meaning framebuffer height in pixels.
REQ-004 SHALL have ports, one per line:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- disp_req  in  1  display read request, front buffer.
- disp_x  in  9  display read column.
- disp_y  in  8  display read row.
- disp_data  out  COLOR_W  display read data.
- disp_valid  out  1  disp_data valid.
- wr_valid  in  1  render write valid.
- wr_ready  out  1  render write ready.
- wr_x  in  9  render write column.
- wr_y  in  8  render write row.
- wr_data  in  COLOR_W  render write pixel.
- swap_req  in  1  pulse: request front/back swap.
- frame_start  in  1  pulse: start of vertical blanking.
- swap_pending  out  1  swap requested, not yet executed.
- front_buf  out  1  bank currently displayed.
- clear_req  in  1  pulse: fill back buffer with clear_color.
- clear_color  in  COLOR_W  fill value.
- clear_busy  out  1  clear in progress.
- mem_addr  out  18  single-port memory address {bank, offset}.
- mem_we  out  1  memory write enable.
- mem_wdata  out  COLOR_W  memory write data.
- mem_rdata  in  COLOR_W  memory read data, valid one cycle after address.

Function
REQ-005 SHALL compute offset = y*H_PIX + x (17 bits); mem_addr = {bank, offset}; mem_addr/mem_we/mem_wdata combinational from current-cycle arbitration.
REQ-006 SHALL grant at most one memory access per cycle, fixed priority: display read > clear write > render write.
REQ-007 Display read: disp_req in cycle k drives mem_addr={front_buf, offset}, mem_we=0; disp_data registered from mem_rdata, disp_valid=1 in cycle k+2; fixed latency 2, back-to-back requests every cycle supported.
REQ-008 Display request with disp_x>=H_PIX or disp_y>=V_PIX: no memory access; disp_valid=1 at k+2 with disp_data=0.
REQ-009 Display read bank SHALL be front_buf as sampled in cycle k, regardless of a swap in cycle k+1.
REQ-010 wr_ready = resetn & ~disp_req & ~clear_busy; transfer when wr_valid & wr_ready: mem_we=1, mem_addr={~front_buf, offset}, mem_wdata=wr_data.
REQ-011 Render write with out-of-range coordinates SHALL complete the handshake and be dropped (mem_we=0).
REQ-012 Clear FSM states IDLE, CLEAR; IDLE + clear_req -> CLEAR, counter=0, color latched from clear_color, clear_busy=1 from next cycle.
REQ-013 In CLEAR, each cycle without disp_req: mem_we=1, mem_addr={~front_buf, counter}, mem_wdata=latched color, counter+1; cycles with disp_req stall the counter.
REQ-014 Write at counter = H_PIX*V_PIX-1 SHALL return FSM to IDLE; clear_busy=0 next cycle.
REQ-015 clear_req during CLEAR SHALL be ignored (no restart, color unchanged).
REQ-016 swap_req SHALL set swap_pending next cycle; swap_req while pending has no effect.
REQ-017 On frame_start with swap_pending=1 and clear_busy=0: front_buf toggles, swap_pending clears, same edge.
REQ-018 frame_start with clear_busy=1 SHALL defer swap to first frame_start after clear completes.
REQ-019 swap_req and frame_start in same cycle with swap_pending=0: no swap this frame; swap_pending=1, executes at next frame_start.

Reset
REQ-020 resetn low SHALL asynchronously force: front_buf=0, swap_pending=0, clear_busy=0, FSM=IDLE, counter=0, disp_valid=0, disp_data=0, in-flight reads discarded; mem_we=0, wr_ready=0 while low.
REQ-021 Reset mid-clear SHALL abort the clear; first cycle after release is IDLE with no memory write.

Verification
REQ-022 disp_req (x=5,y=2), front_buf=0, mem_rdata=0x3FF -> mem_addr=0x00285, disp_valid and disp_data=0x3FF exactly 2 cycles later.
REQ-023 wr_valid=1 (x=319,y=239) with disp_req=1 -> wr_ready=0; next cycle disp_req=0 -> mem_we=1, mem_addr={1,76799}.
REQ-024 clear_req, color 0x155, disp_req every other cycle -> 76800 writes to bank 1 addr 0..76799, clear_busy high until last write, no render write granted during clear.
REQ-025 swap_req then frame_start during clear -> front_buf stays 0; frame_start after clear_busy falls -> front_buf=1, swap_pending=0.
REQ-026 disp_req with x=320 -> no memory access, disp_valid=1, disp_data=0 at latency 2.
REQ-027 resetn low at counter=1000 during clear -> clear_busy=0, front_buf=0, disp_valid=0 immediately; no writes after release until new request.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - double-buffered framebuffer port arbiter (display read, clear, render write)
module framebuffer_arbiter #(
    parameter int COLOR_W = 30,
    parameter int H_PIX   = 320,
    parameter int V_PIX   = 240
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               disp_req,
    input  logic [8:0]         disp_x,
    input  logic [7:0]         disp_y,
    output logic [COLOR_W-1:0] disp_data,
    output logic               disp_valid,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [8:0]         wr_x,
    input  logic [7:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               swap_req,
    input  logic               frame_start,
    output logic               swap_pending,
    output logic               front_buf,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic [17:0]        mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata
);

    localparam logic [9:0]  H_LIM    = 10'(H_PIX);
    localparam logic [8:0]  V_LIM    = 9'(V_PIX);
    localparam logic [16:0] H_MUL    = 17'(H_PIX);
    localparam logic [16:0] LAST_PIX = 17'(H_PIX * V_PIX - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [16:0]        cnt_q, cnt_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               front_q;
    logic               pend_q;
    logic               rd_pend_q;
    logic               rd_oob_q;
    logic               disp_valid_q;
    logic [COLOR_W-1:0] disp_data_q;

    logic               disp_in_range;
    logic               wr_in_range;
    logic [16:0]        disp_off;
    logic [16:0]        wr_off;

    assign disp_in_range = ({1'b0, disp_x} < H_LIM) && ({1'b0, disp_y} < V_LIM);
    assign wr_in_range   = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);
    assign disp_off      = 17'(disp_y) * H_MUL + 17'(disp_x);
    assign wr_off        = 17'(wr_y) * H_MUL + 17'(wr_x);

    assign clear_busy    = (state_q == ST_CLEAR);
    assign wr_ready      = resetn & ~disp_req & ~clear_busy;
    assign front_buf     = front_q;
    assign swap_pending  = pend_q;
    assign disp_valid    = disp_valid_q;
    assign disp_data     = disp_data_q;

    // Clear FSM state, fill counter and latched fill colour
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

    // Single-port grant (display > clear > render) and clear FSM next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        color_d   = color_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_req) begin
            // out-of-range reads leave the port idle; the pipeline returns zero
            if (disp_in_range) begin
                mem_addr = {front_q, disp_off};
            end
        end else if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = {~front_q, cnt_q};
            mem_wdata = color_q;
            if (cnt_q == LAST_PIX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_we    = 1'b1;
            mem_addr  = {~front_q, wr_off};
            mem_wdata = wr_data;
        end
        if (state_q == ST_IDLE && clear_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            color_d = clear_color;
        end
    end

    // Two-stage display read pipeline: address cycle, then capture of mem_rdata
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_pend_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd_pend_q    <= disp_req;
            rd_oob_q     <= ~disp_in_range;
            disp_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                disp_data_q <= rd_oob_q ? '0 : mem_rdata;
            end
        end
    end

    // Swap request latch; the flip waits for vblank and for any clear to finish
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else if (frame_start && pend_q && !clear_busy) begin
            front_q <= ~front_q;
            pend_q  <= 1'b0;
        end else if (swap_req) begin
            pend_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - scoreboard bench for framebuffer_arbiter
module tb_framebuffer_arbiter;

    localparam int CW = 30;
    localparam int H  = 320;
    localparam int V  = 8;
    localparam int N  = H * V;

    typedef struct {
        logic [CW-1:0] data;
        int            cyc;
    } rd_exp_t;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic          disp_req;
    logic [8:0]    disp_x;
    logic [7:0]    disp_y;
    logic [CW-1:0] disp_data;
    logic          disp_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [8:0]    wr_x;
    logic [7:0]    wr_y;
    logic [CW-1:0] wr_data;
    logic          swap_req;
    logic          frame_start;
    logic          swap_pending;
    logic          front_buf;
    logic          clear_req;
    logic [CW-1:0] clear_color;
    logic          clear_busy;
    logic [17:0]   mem_addr;
    logic          mem_we;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata = '0;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int wr_pops = 0;
    logic exp_front = 1'b0;

    rd_exp_t     exp_rd_q[$];
    logic [47:0] exp_wr_q[$];

    framebuffer_arbiter #(.COLOR_W(CW), .H_PIX(H), .V_PIX(V)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .swap_req(swap_req), .frame_start(frame_start),
        .swap_pending(swap_pending), .front_buf(front_buf),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [CW-1:0] mem_val(input logic [17:0] a);
        if (a == 18'h00285) return 30'h3FF;
        return {a[11:0], a} ^ 30'h15A5A5A5;
    endfunction

    function automatic logic [16:0] off(input int x, input int y);
        return 17'(y * H + x);
    endfunction

    // memory stub: read data one cycle after the address
    always @(posedge CLOCK_50) mem_rdata <= mem_val(mem_addr);

    // monitor: pop and compare whenever the DUT presents read data or a write
    always @(negedge CLOCK_50) begin
        rd_exp_t     e;
        logic [47:0] w;
        if (disp_valid) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL disp_unexpected data=%h cyc=%0d", disp_data, cyc);
            end else begin
                e = exp_rd_q.pop_front();
                if (disp_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL disp_read got data=%h cyc=%0d want data=%h cyc=%0d",
                             disp_data, cyc, e.data, e.cyc);
                end
            end
        end
        if (mem_we) begin
            checks++;
            wr_pops++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                w = exp_wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== w) begin
                    errors++;
                    $display("FAIL mem_write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_wdata, w[47:30], w[29:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic sample();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // present a display read this cycle and queue its expected result
    task automatic issue_read(input int x, input int y);
        rd_exp_t e;
        disp_req = 1'b1;
        disp_x   = 9'(x);
        disp_y   = 8'(y);
        e.data   = (x < H && y < V) ? mem_val({exp_front, off(x, y)}) : '0;
        e.cyc    = cyc + 2;
        exp_rd_q.push_back(e);
    endtask

    task automatic pulse_swap(input logic s, input logic f);
        tick();
        swap_req    = s;
        frame_start = f;
        tick();
        swap_req    = 1'b0;
        frame_start = 1'b0;
        sample();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; disp_req = 1'b0; disp_x = '0; disp_y = '0;
        wr_valid = 1'b1; wr_x = 9'd1; wr_y = 8'd1; wr_data = 30'h123;
        swap_req = 1'b0; frame_start = 1'b0; clear_req = 1'b0; clear_color = '0;

        // reset state, with a render write offered
        tick(); tick(); sample();
        chk("rst_front", 48'(front_buf), 48'd0);
        chk("rst_pending", 48'(swap_pending), 48'd0);
        chk("rst_busy", 48'(clear_busy), 48'd0);
        chk("rst_valid", 48'(disp_valid), 48'd0);
        chk("rst_data", 48'(disp_data), 48'd0);
        chk("rst_wr_ready", 48'(wr_ready), 48'd0);
        chk("rst_mem_we", 48'(mem_we), 48'd0);
        tick();
        resetn = 1'b1; wr_valid = 1'b0;

        // display read (5,2): address and 2-cycle latency
        tick();
        issue_read(5, 2);
        sample();
        chk("rd_addr", 48'(mem_addr), 48'h00285);
        chk("rd_we", 48'(mem_we), 48'd0);

        // back-to-back reads incl. column/row boundaries
        tick(); issue_read(319, 7);
        tick(); issue_read(320, 0);
        sample();
        chk("oob_rd_we", 48'(mem_we), 48'd0);
        tick(); issue_read(0, 8);
        tick(); issue_read(0, 0);
        tick(); disp_req = 1'b0;

        // render write blocked by display read, then granted
        tick();
        issue_read(10, 3);
        wr_valid = 1'b1; wr_x = 9'd319; wr_y = 8'd7; wr_data = 30'h2AAAAAAA;
        sample();
        chk("wr_ready_blocked", 48'(wr_ready), 48'd0);
        chk("wr_blocked_we", 48'(mem_we), 48'd0);
        tick();
        disp_req = 1'b0;
        exp_wr_q.push_back({~exp_front, off(319, 7), 30'h2AAAAAAA});
        sample();
        chk("wr_ready_free", 48'(wr_ready), 48'd1);
        tick();
        wr_x = 9'd1; wr_y = 8'd1; wr_data = 30'h0BEEF;
        exp_wr_q.push_back({~exp_front, off(1, 1), 30'h0BEEF});
        tick();
        wr_x = 9'd320; wr_y = 8'd0;
        sample();
        chk("oob_wr_ready", 48'(wr_ready), 48'd1);
        chk("oob_wr_we", 48'(mem_we), 48'd0);
        tick();
        wr_x = 9'd0; wr_y = 8'd8;
        sample();
        chk("oob_wr_we_row", 48'(mem_we), 48'd0);
        tick();
        wr_valid = 1'b0;

        // swap_req with frame_start together: pend only
        pulse_swap(1'b1, 1'b1);
        chk("same_cyc_front", 48'(front_buf), 48'd0);
        chk("same_cyc_pending", 48'(swap_pending), 48'd1);
        pulse_swap(1'b1, 1'b0);
        chk("repeat_req_front", 48'(front_buf), 48'd0);
        pulse_swap(1'b0, 1'b1);
        exp_front = 1'b1;
        chk("swap_front", 48'(front_buf), 48'd1);
        chk("swap_pending_clr", 48'(swap_pending), 48'd0);
        tick(); issue_read(5, 2);
        tick(); disp_req = 1'b0;
        pulse_swap(1'b1, 1'b0);
        pulse_swap(1'b0, 1'b1);
        exp_front = 1'b0;
        chk("swap_back_front", 48'(front_buf), 48'd0);

        // full clear of bank 1 with interleaved reads, ignored re-request and deferred swap
        begin
            int base;
            bit done;
            done = 1'b0;
            tick();
            clear_req = 1'b1; clear_color = 30'h155;
            for (int i = 0; i < N; i++) exp_wr_q.push_back({1'b1, 17'(i), 30'h155});
            tick();
            clear_req = 1'b0;
            base = wr_pops;
            sample();
            chk("clear_busy_set", 48'(clear_busy), 48'd1);
            for (int i = 0; i < 20000 && !done; i++) begin
                tick();
                clear_req = (i == 10);
                clear_color = (i == 10) ? 30'h2AA : 30'h155;
                swap_req = (i == 20);
                frame_start = (i == 30);
                wr_valid = 1'b1; wr_x = 9'd2; wr_y = 8'd2; wr_data = 30'h3;
                if (i[0]) issue_read((i * 7) % H, (i / 3) % (V + 1));
                else disp_req = 1'b0;
                sample();
                if (i == 40) begin
                    chk("defer_front", 48'(front_buf), 48'd0);
                    chk("defer_pending", 48'(swap_pending), 48'd1);
                    chk("clear_wr_ready", 48'(wr_ready), 48'd0);
                end
                if (!clear_busy) begin
                    done = 1'b1;
                    wr_valid = 1'b0;
                end
            end
            chk("clear_finished", 48'(done), 48'd1);
            chk("clear_write_count", 48'(wr_pops - base), 48'(N));
            tick();
            disp_req = 1'b0; wr_valid = 1'b0;
            sample();
            chk("post_clear_front", 48'(front_buf), 48'd0);
            pulse_swap(1'b0, 1'b1);
            exp_front = 1'b1;
            chk("post_clear_swap", 48'(front_buf), 48'd1);
            chk("post_clear_pending", 48'(swap_pending), 48'd0);
        end

        // reset in the middle of a clear of bank 0
        begin
            int base;
            bit hit;
            hit = 1'b0;
            tick();
            clear_req = 1'b1; clear_color = 30'h0AB;
            for (int i = 0; i < 1000; i++) exp_wr_q.push_back({1'b0, 17'(i), 30'h0AB});
            tick();
            clear_req = 1'b0;
            base = wr_pops;
            for (int i = 0; i < 3000 && !hit; i++) begin
                sample();
                if (wr_pops - base >= 1000) hit = 1'b1;
            end
            chk("reach_1000", 48'(hit), 48'd1);
            tick();
            resetn = 1'b0;
            wr_valid = 1'b1; wr_x = 9'd4; wr_y = 8'd4;
            #1;
            exp_front = 1'b0;
            chk("abort_busy", 48'(clear_busy), 48'd0);
            chk("abort_front", 48'(front_buf), 48'd0);
            chk("abort_valid", 48'(disp_valid), 48'd0);
            chk("abort_we", 48'(mem_we), 48'd0);
            chk("abort_wr_ready", 48'(wr_ready), 48'd0);
            tick(); tick();
            wr_valid = 1'b0;
            resetn = 1'b1;
            for (int i = 0; i < 20; i++) tick();
            sample();
            chk("release_busy", 48'(clear_busy), 48'd0);
        end

        // in-flight read dropped by reset
        tick(); disp_req = 1'b1; disp_x = 9'd3; disp_y = 8'd3;
        tick(); disp_req = 1'b0; resetn = 1'b0;
        tick(); tick(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick(); issue_read(5, 2);
        tick(); disp_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        sample();
        chk("rd_queue_empty", 48'(exp_rd_q.size()), 48'd0);
        chk("wr_queue_empty", 48'(exp_wr_q.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
